// File: rtl/md5_update.sv
// Iterative MD5 compression: one 512-bit block per run, one round per clock.
// Define MD5_FEEDFORWARD_EN to return the new chaining value (A..D added back) instead of the raw result.
module md5_update (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] str,
    input  logic         en,
    input  logic [8:0]   input_len,
    input  logic [31:0]  A,
    input  logic [31:0]  B,
    input  logic [31:0]  C,
    input  logic [31:0]  D,
    output logic         complete,
    output logic [31:0]  a,
    output logic [31:0]  b,
    output logic [31:0]  c,
    output logic [31:0]  d
);

    typedef enum logic [1:0] {IDLE, RUN, DONE_WAIT} state_t;

    state_t        state_reg, state_next;
    logic          armed_reg;
    logic [5:0]    round_reg;
    logic [511:0]  blk_reg;
    logic [8:0]    len_reg;
    logic [31:0]   wa_reg, wb_reg, wc_reg, wd_reg;
    logic [31:0]   a_reg, b_reg, c_reg, d_reg;
    logic          complete_reg;
    logic          accept, finish, rearm;
    logic [31:0]   m_word [16];
    logic [31:0]   f_val, k_val, t_val, rot_val, new_b;
    logic [3:0]    g_idx;
    logic [4:0]    s_amt;
    logic [31:0]   res_a, res_b, res_c, res_d;
    logic          unused_len;

`ifdef MD5_FEEDFORWARD_EN
    logic [31:0]   iva_reg, ivb_reg, ivc_reg, ivd_reg;
`endif

    // Byte count is carried along for the front-end but never affects the hash.
    assign unused_len = ^len_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_words
            assign m_word[gi] = blk_reg[32*gi +: 32];
        end
    endgenerate

    function automatic logic [31:0] k_const(input logic [5:0] i);
        logic [31:0] k;
        k = 32'h0;
        case (i)
            6'd0:  k = 32'hd76aa478; 6'd1:  k = 32'he8c7b756; 6'd2:  k = 32'h242070db; 6'd3:  k = 32'hc1bdceee;
            6'd4:  k = 32'hf57c0faf; 6'd5:  k = 32'h4787c62a; 6'd6:  k = 32'ha8304613; 6'd7:  k = 32'hfd469501;
            6'd8:  k = 32'h698098d8; 6'd9:  k = 32'h8b44f7af; 6'd10: k = 32'hffff5bb1; 6'd11: k = 32'h895cd7be;
            6'd12: k = 32'h6b901122; 6'd13: k = 32'hfd987193; 6'd14: k = 32'ha679438e; 6'd15: k = 32'h49b40821;
            6'd16: k = 32'hf61e2562; 6'd17: k = 32'hc040b340; 6'd18: k = 32'h265e5a51; 6'd19: k = 32'he9b6c7aa;
            6'd20: k = 32'hd62f105d; 6'd21: k = 32'h02441453; 6'd22: k = 32'hd8a1e681; 6'd23: k = 32'he7d3fbc8;
            6'd24: k = 32'h21e1cde6; 6'd25: k = 32'hc33707d6; 6'd26: k = 32'hf4d50d87; 6'd27: k = 32'h455a14ed;
            6'd28: k = 32'ha9e3e905; 6'd29: k = 32'hfcefa3f8; 6'd30: k = 32'h676f02d9; 6'd31: k = 32'h8d2a4c8a;
            6'd32: k = 32'hfffa3942; 6'd33: k = 32'h8771f681; 6'd34: k = 32'h6d9d6122; 6'd35: k = 32'hfde5380c;
            6'd36: k = 32'ha4beea44; 6'd37: k = 32'h4bdecfa9; 6'd38: k = 32'hf6bb4b60; 6'd39: k = 32'hbebfbc70;
            6'd40: k = 32'h289b7ec6; 6'd41: k = 32'heaa127fa; 6'd42: k = 32'hd4ef3085; 6'd43: k = 32'h04881d05;
            6'd44: k = 32'hd9d4d039; 6'd45: k = 32'he6db99e5; 6'd46: k = 32'h1fa27cf8; 6'd47: k = 32'hc4ac5665;
            6'd48: k = 32'hf4292244; 6'd49: k = 32'h432aff97; 6'd50: k = 32'hab9423a7; 6'd51: k = 32'hfc93a039;
            6'd52: k = 32'h655b59c3; 6'd53: k = 32'h8f0ccc92; 6'd54: k = 32'hffeff47d; 6'd55: k = 32'h85845dd1;
            6'd56: k = 32'h6fa87e4f; 6'd57: k = 32'hfe2ce6e0; 6'd58: k = 32'ha3014314; 6'd59: k = 32'h4e0811a1;
            6'd60: k = 32'hf7537e82; 6'd61: k = 32'hbd3af235; 6'd62: k = 32'h2ad7d2bb; 6'd63: k = 32'heb86d391;
            default: k = 32'h0;
        endcase
        return k;
    endfunction

    always_comb begin
        f_val = 32'h0;
        g_idx = 4'h0;
        case (round_reg[5:4])
            2'd0: begin f_val = (wb_reg & wc_reg) | (~wb_reg & wd_reg); g_idx = round_reg[3:0]; end
            2'd1: begin f_val = (wd_reg & wb_reg) | (~wd_reg & wc_reg); g_idx = round_reg[3:0] * 4'd5 + 4'd1; end
            2'd2: begin f_val = wb_reg ^ wc_reg ^ wd_reg;               g_idx = round_reg[3:0] * 4'd3 + 4'd5; end
            default: begin f_val = wc_reg ^ (wb_reg | ~wd_reg);         g_idx = round_reg[3:0] * 4'd7; end
        endcase
    end

    always_comb begin
        s_amt = 5'd0;
        case ({round_reg[5:4], round_reg[1:0]})
            4'h0: s_amt = 5'd7;  4'h1: s_amt = 5'd12; 4'h2: s_amt = 5'd17; 4'h3: s_amt = 5'd22;
            4'h4: s_amt = 5'd5;  4'h5: s_amt = 5'd9;  4'h6: s_amt = 5'd14; 4'h7: s_amt = 5'd20;
            4'h8: s_amt = 5'd4;  4'h9: s_amt = 5'd11; 4'ha: s_amt = 5'd16; 4'hb: s_amt = 5'd23;
            4'hc: s_amt = 5'd6;  4'hd: s_amt = 5'd10; 4'he: s_amt = 5'd15; default: s_amt = 5'd21;
        endcase
    end

    assign k_val   = k_const(round_reg);
    assign t_val   = wa_reg + f_val + k_val + m_word[g_idx];
    assign rot_val = (t_val << s_amt) | (t_val >> (6'd32 - {1'b0, s_amt}));
    assign new_b   = wb_reg + rot_val;

    // Result is taken from the post-round-63 register values, so it is ready on the same edge.
    always_comb begin
`ifdef MD5_FEEDFORWARD_EN
        res_a = iva_reg + wd_reg;
        res_b = ivb_reg + new_b;
        res_c = ivc_reg + wb_reg;
        res_d = ivd_reg + wc_reg;
`else
        res_a = wd_reg;
        res_b = new_b;
        res_c = wb_reg;
        res_d = wc_reg;
`endif
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        rearm      = 1'b0;
        case (state_reg)
            IDLE:      if (en && armed_reg) begin accept = 1'b1; state_next = RUN; end
            RUN:       if (round_reg == 6'd63) begin finish = 1'b1; state_next = DONE_WAIT; end
            DONE_WAIT: if (!en) begin rearm = 1'b1; state_next = IDLE; end
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            armed_reg    <= 1'b1;
            round_reg    <= 6'd0;
            blk_reg      <= '0;
            len_reg      <= '0;
            wa_reg       <= '0;
            wb_reg       <= '0;
            wc_reg       <= '0;
            wd_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            c_reg        <= '0;
            d_reg        <= '0;
            complete_reg <= 1'b0;
`ifdef MD5_FEEDFORWARD_EN
            iva_reg      <= '0;
            ivb_reg      <= '0;
            ivc_reg      <= '0;
            ivd_reg      <= '0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                blk_reg   <= str;
                len_reg   <= input_len;
                wa_reg    <= A;
                wb_reg    <= B;
                wc_reg    <= C;
                wd_reg    <= D;
                round_reg <= 6'd0;
`ifdef MD5_FEEDFORWARD_EN
                iva_reg   <= A;
                ivb_reg   <= B;
                ivc_reg   <= C;
                ivd_reg   <= D;
`endif
            end
            if (state_reg == RUN) begin
                wa_reg <= wd_reg;
                wd_reg <= wc_reg;
                wc_reg <= wb_reg;
                wb_reg <= new_b;
                if (!finish) round_reg <= round_reg + 6'd1;
            end
            if (finish) begin
                complete_reg <= ~complete_reg;
                armed_reg    <= 1'b0;
                a_reg        <= res_a;
                b_reg        <= res_b;
                c_reg        <= res_c;
                d_reg        <= res_d;
            end
            if (rearm) armed_reg <= 1'b1;
        end
    end

    assign complete = complete_reg;
    assign a = a_reg;
    assign b = b_reg;
    assign c = c_reg;
    assign d = d_reg;

endmodule

// File: tb/tb_md5_update.sv
// Directed bench for md5_update: empty and "abc" blocks, level-held en, mid-run input changes and reset.
// Expected values follow the MD5_FEEDFORWARD_EN build setting.
module tb_md5_update;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] str;
    logic         en;
    logic [8:0]   input_len;
    logic [31:0]  A, B, C, D;
    logic         complete;
    logic [31:0]  a, b, c, d;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_empty [4];
    logic [31:0] exp_abc   [4];

    md5_update dut (
        .clk(clk), .rst(rst), .str(str), .en(en), .input_len(input_len),
        .A(A), .B(B), .C(C), .D(D),
        .complete(complete), .a(a), .b(b), .c(c), .d(d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_iv();
        A = 32'h67452301; B = 32'hefcdab89; C = 32'h98badcfe; D = 32'h10325476;
    endtask

    // Raises en at a falling edge; the following rising edge is the accepting edge.
    task automatic start_block();
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
    endtask

    // Counts rising edges until complete changes, bounded so a dead DUT cannot hang the run.
    task automatic wait_toggle(input string tag, input int exp_n);
        logic prev;
        int n;
        prev = complete;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (complete !== prev) break;
        end
        chk(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic drop_en();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
`ifdef MD5_FEEDFORWARD_EN
        exp_empty = '{32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec};
        exp_abc   = '{32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128};
`else
        exp_empty = '{32'h7246fad3, 32'h14e45506, 32'hff4ea3eb, 32'h6e10a476};
        exp_abc   = '{32'h310ade8f, 32'hc08226b3, 32'he484b9d8, 32'h624d8cb2};
`endif
        rst = 1'b1;
        en = 1'b0;
        str = '0;
        input_len = 9'd0;
        set_iv();
        #12;
        chk("rst_complete", {31'b0, complete}, 32'd0);
        chk("rst_a", a, 32'h0);
        chk("rst_b", b, 32'h0);
        chk("rst_c", c, 32'h0);
        chk("rst_d", d, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Empty message block
        str = 512'h80;
        input_len = 9'd0;
        start_block();
        wait_toggle("empty_latency", 64);
        chk("empty_a", a, exp_empty[0]);
        chk("empty_b", b, exp_empty[1]);
        chk("empty_c", c, exp_empty[2]);
        chk("empty_d", d, exp_empty[3]);

        // Level-held en must not restart
        repeat (300) @(posedge clk);
        #1;
        chk("hold_complete", {31'b0, complete}, 32'd1);
        chk("hold_a", a, exp_empty[0]);
        drop_en();

        // "abc" block; inputs scrambled mid-run must be ignored
        str = '0;
        str[31:0] = 32'h80636261;
        str[511:448] = 64'h18;
        input_len = 9'd3;
        start_block();
        repeat (5) @(posedge clk);
        #1;
        chk("midrun_b_hold", b, exp_empty[1]);
        @(negedge clk);
        str = {16{32'hdeadbeef}};
        A = 32'h11111111; B = 32'h22222222; C = 32'h33333333; D = 32'h44444444;
        en = 1'b0;
        wait_toggle("abc_latency", 59);
        chk("abc_a", a, exp_abc[0]);
        chk("abc_b", b, exp_abc[1]);
        chk("abc_c", c, exp_abc[2]);
        chk("abc_d", d, exp_abc[3]);
        chk("two_runs_cmpl", {31'b0, complete}, 32'd0);
        drop_en();

        // Third block back to complete=1
        str = 512'h80;
        set_iv();
        start_block();
        wait_toggle("third_latency", 64);
        chk("third_a", a, exp_empty[0]);
        chk("third_d", d, exp_empty[3]);
        drop_en();

        // Reset in the middle of a fourth run
        start_block();
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_complete", {31'b0, complete}, 32'd0);
        chk("abort_a", a, 32'h0);
        chk("abort_b", b, 32'h0);
        chk("abort_c", c, 32'h0);
        chk("abort_d", d, 32'h0);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("post_abort_cmpl", {31'b0, complete}, 32'd0);
        chk("post_abort_a", a, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
